// File: rtl/frame_pkg.sv
// ============================================================================
// Module   : frame_pkg
// Brief    : Shared frame constants, FSM state type and reference frame generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_pkg;

  localparam logic [7:0]  K28_5      = 8'hBC;
  localparam logic [15:0] COMMA_WORD = {K28_5, K28_5};
  localparam logic [1:0]  COMMA_K    = 2'b11;
  localparam int          FRAME_LEN  = 4;
  localparam int          IDX_W      = $clog2(FRAME_LEN);

  // Entry [0] is the comma word; the rest are plain data words.
  localparam logic [FRAME_LEN-1:0][15:0] FRAME_PATTERN =
    {16'h23A7, 16'h4034, 16'h5854, COMMA_WORD};

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Reference generator: returns {K flags, word} for a position in the frame.
  function automatic logic [17:0] frame_gen(input logic [IDX_W-1:0] idx);
    return {((idx == '0) ? COMMA_K : 2'b00), FRAME_PATTERN[idx]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_aligner.sv
// ============================================================================
// Module   : byte_aligner
// Brief    : Keeps the previous high byte, detects commas in both byte lanes
//            and muxes the selected lane onto the candidate word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_aligner
  import frame_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [15:0] i_rx_data,
  input  logic [1:0]  i_rx_is_k,
  input  logic        i_lane_sel,
  output logic [15:0] o_cand_data,
  output logic [1:0]  o_cand_is_k,
  output logic        o_direct_hit,
  output logic        o_shifted_hit
);

  logic [7:0]  r_prev_hi;
  logic        r_prev_k_hi;
  logic [15:0] w_shift_data;
  logic [1:0]  w_shift_k;

  // Only the upper byte of the previous word ever feeds the shifted lane.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_prev_hi   <= '0;
      r_prev_k_hi <= 1'b0;
    end else begin
      r_prev_hi   <= i_rx_data[15:8];
      r_prev_k_hi <= i_rx_is_k[1];
    end
  end

  assign w_shift_data  = {i_rx_data[7:0], r_prev_hi};
  assign w_shift_k     = {i_rx_is_k[0], r_prev_k_hi};

  assign o_direct_hit  = (i_rx_data == COMMA_WORD) && (i_rx_is_k == COMMA_K);
  assign o_shifted_hit = (w_shift_data == COMMA_WORD) && (w_shift_k == COMMA_K);

  assign o_cand_data   = i_lane_sel ? w_shift_data : i_rx_data;
  assign o_cand_is_k   = i_lane_sel ? w_shift_k    : i_rx_is_k;

endmodule

`default_nettype wire

// File: rtl/frame_checker.sv
// ============================================================================
// Module   : frame_checker
// Brief    : Byte-aligns a 16-bit GTP rx stream, hunts/locks on the reference
//            frame and counts good frames and word errors while locked.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_checker
  import frame_pkg::*;
#(
  parameter int LOCK_FRAMES   = 4,
  parameter int UNLOCK_FRAMES = 4,
  parameter int CNT_W         = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             rx_ready,
  input  logic [15:0]      rx_data,
  input  logic [1:0]       rx_is_k,
  input  logic             cnt_clear,
  output logic [15:0]      aligned_data,
  output logic [1:0]       aligned_is_k,
  output logic             aligned_valid,
  output logic             lane_swap,
  output logic             locked,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam int BAD_W  = $clog2(UNLOCK_FRAMES + 1);
  localparam logic [GOOD_W-1:0] C_GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);
  localparam logic [BAD_W-1:0]  C_BAD_LAST  = BAD_W'(UNLOCK_FRAMES - 1);
  localparam logic [IDX_W-1:0]  C_IDX_LAST  = IDX_W'(FRAME_LEN - 1);

  state_t            r_state, w_state_next;
  logic [IDX_W-1:0]  r_idx;
  logic [GOOD_W-1:0] r_good;
  logic [BAD_W-1:0]  r_bad_run;
  logic              r_frame_bad, r_lane_swap, w_lane_next;
  logic [CNT_W-1:0]  r_frame_cnt, r_err_cnt;
  logic [15:0]       w_cand_data, r_cand_d1, r_aligned_data;
  logic [1:0]        w_cand_is_k, r_cand_k_d1, r_aligned_is_k;
  logic              r_ready_d1, r_aligned_valid;
  logic              w_direct_hit, w_shifted_hit, w_hunt_hit;
  logic              w_match, w_frame_end, w_frame_bad;
  logic              w_locked, w_err_inc, w_frame_inc;
  logic [17:0]       w_exp;

  byte_aligner u_aligner (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .i_rx_data     (rx_data),
    .i_rx_is_k     (rx_is_k),
    .i_lane_sel    (w_lane_next),
    .o_cand_data   (w_cand_data),
    .o_cand_is_k   (w_cand_is_k),
    .o_direct_hit  (w_direct_hit),
    .o_shifted_hit (w_shifted_hit)
  );

  // The lane may only move in HUNT; on a double hit the direct lane wins.
  always_comb begin
    w_lane_next = r_lane_swap;
    if (r_state == ST_HUNT && rx_ready) begin
      if (w_direct_hit)       w_lane_next = 1'b0;
      else if (w_shifted_hit) w_lane_next = 1'b1;
    end
  end

  assign w_hunt_hit  = rx_ready && (w_direct_hit || w_shifted_hit);
  assign w_exp       = frame_gen(r_idx);
  assign w_match     = ({w_cand_is_k, w_cand_data} == w_exp);
  assign w_frame_end = (r_idx == C_IDX_LAST);
  assign w_frame_bad = r_frame_bad || !w_match;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_HUNT;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (!rx_ready) begin
      w_state_next = ST_HUNT;
    end else begin
      case (r_state)
        ST_HUNT:   if (w_hunt_hit) w_state_next = ST_CHECK;
        ST_CHECK: begin
          if (!w_match)                                 w_state_next = ST_HUNT;
          else if (w_frame_end && r_good == C_GOOD_LAST) w_state_next = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (w_frame_end && w_frame_bad && r_bad_run == C_BAD_LAST)
            w_state_next = ST_HUNT;
        end
        default:   w_state_next = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    w_locked    = 1'b0;
    w_err_inc   = 1'b0;
    w_frame_inc = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_locked = 1'b1;
      if (rx_ready) begin
        w_err_inc   = !w_match;
        w_frame_inc = w_frame_end && !w_frame_bad;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_idx       <= '0;
      r_good      <= '0;
      r_bad_run   <= '0;
      r_frame_bad <= 1'b0;
      r_lane_swap <= 1'b0;
    end else begin
      r_lane_swap <= w_lane_next;
      if (!rx_ready) begin
        r_idx       <= '0;
        r_good      <= '0;
        r_bad_run   <= '0;
        r_frame_bad <= 1'b0;
      end else begin
        case (r_state)
          ST_HUNT: begin
            r_good      <= '0;
            r_bad_run   <= '0;
            r_frame_bad <= 1'b0;
            r_idx       <= w_hunt_hit ? IDX_W'(1) : '0;
          end
          ST_CHECK: begin
            if (!w_match) begin
              r_idx  <= '0;
              r_good <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
              if (w_frame_end) r_good <= r_good + GOOD_W'(1);
            end
          end
          ST_LOCKED: begin
            r_idx <= r_idx + IDX_W'(1);
            if (w_frame_end) begin
              r_frame_bad <= 1'b0;
              if (!w_frame_bad || r_bad_run == C_BAD_LAST) r_bad_run <= '0;
              else                                         r_bad_run <= r_bad_run + BAD_W'(1);
            end else begin
              r_frame_bad <= w_frame_bad;
            end
          end
          default: r_idx <= '0;
        endcase
      end
    end
  end

  // Clear has priority over increment; both counters stick at all-ones.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (cnt_clear) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_frame_inc && r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      if (w_err_inc && r_err_cnt != '1)     r_err_cnt   <= r_err_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cand_d1       <= '0;
      r_cand_k_d1     <= '0;
      r_ready_d1      <= 1'b0;
      r_aligned_data  <= '0;
      r_aligned_is_k  <= '0;
      r_aligned_valid <= 1'b0;
    end else begin
      r_cand_d1       <= w_cand_data;
      r_cand_k_d1     <= w_cand_is_k;
      r_ready_d1      <= rx_ready;
      r_aligned_data  <= r_cand_d1;
      r_aligned_is_k  <= r_cand_k_d1;
      r_aligned_valid <= r_ready_d1 && (w_state_next != ST_HUNT);
    end
  end

  assign aligned_data  = r_aligned_data;
  assign aligned_is_k  = r_aligned_is_k;
  assign aligned_valid = r_aligned_valid;
  assign lane_swap     = r_lane_swap;
  assign locked        = w_locked;
  assign frame_cnt     = r_frame_cnt;
  assign err_cnt       = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_frame_checker.sv
// ============================================================================
// Module   : tb_frame_checker
// Brief    : Directed self-checking bench for frame_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_checker;

  logic        aclk      = 1'b0;
  logic        aresetn   = 1'b0;
  logic        rx_ready  = 1'b0;
  logic        cnt_clear = 1'b0;
  logic [15:0] rx_data   = '0;
  logic [1:0]  rx_is_k   = '0;

  logic [15:0] aligned_data;
  logic [1:0]  aligned_is_k;
  logic        aligned_valid, lane_swap, locked;
  logic [31:0] frame_cnt, err_cnt;

  logic [15:0] w4_aligned_data;
  logic [1:0]  w4_aligned_is_k;
  logic        w4_aligned_valid, w4_lane_swap, w4_locked;
  logic [3:0]  w4_frame_cnt, w4_err_cnt;

  int checks   = 0;
  int failures = 0;

  logic [15:0] pat [4] = '{16'hBCBC, 16'h5854, 16'h4034, 16'h23A7};
  logic [1:0]  pk  [4] = '{2'b11, 2'b00, 2'b00, 2'b00};

  frame_checker dut (
    .aclk(aclk), .aresetn(aresetn), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_is_k(rx_is_k), .cnt_clear(cnt_clear), .aligned_data(aligned_data),
    .aligned_is_k(aligned_is_k), .aligned_valid(aligned_valid),
    .lane_swap(lane_swap), .locked(locked), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  frame_checker #(.CNT_W(4)) dut_w4 (
    .aclk(aclk), .aresetn(aresetn), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_is_k(rx_is_k), .cnt_clear(cnt_clear), .aligned_data(w4_aligned_data),
    .aligned_is_k(w4_aligned_is_k), .aligned_valid(w4_aligned_valid),
    .lane_swap(w4_lane_swap), .locked(w4_locked), .frame_cnt(w4_frame_cnt),
    .err_cnt(w4_err_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic [1:0] k);
    @(negedge aclk);
    rx_data = d;
    rx_is_k = k;
  endtask

  task automatic after_edge;
    @(posedge aclk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] bad);
    for (int i = 0; i < 4; i++) drive(pat[i] ^ (bad[i] ? 16'h0001 : 16'h0000), pk[i]);
  endtask

  // Stream delayed by one byte: low byte of each rx word is the previous word's high byte.
  task automatic send_shift(input int gi);
    drive({pat[(gi + 1) % 4][7:0], pat[gi][15:8]}, {pk[(gi + 1) % 4][0], pk[gi][1]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge aclk);
    after_edge;
    check_val("rst_locked", locked, 0);
    check_val("rst_lane", lane_swap, 0);
    check_val("rst_valid", aligned_valid, 0);
    check_val("rst_data", aligned_data, 0);
    check_val("rst_frame_cnt", frame_cnt, 0);
    check_val("rst_err_cnt", err_cnt, 0);

    @(negedge aclk);
    aresetn  = 1'b1;
    rx_ready = 1'b1;

    // aligned stream: lock on the 4th frame's last word
    for (int s = 0; s < 15; s++) drive(pat[s % 4], pk[s % 4]);
    after_edge;
    check_val("lock_early", locked, 0);
    drive(pat[3], pk[3]);
    after_edge;
    check_val("lock_direct", locked, 1);
    check_val("lane_direct", lane_swap, 0);
    check_val("err_after_lock", err_cnt, 0);
    check_val("frame_after_lock", frame_cnt, 0);
    check_val("aligned_lat2", aligned_data, 16'h4034);
    check_val("aligned_valid_lock", aligned_valid, 1);

    send_frame(4'b0000);
    after_edge;
    check_val("frame_cnt_1", frame_cnt, 1);
    send_frame(4'b0100);
    after_edge;
    check_val("err_one", err_cnt, 1);
    check_val("frame_bad_skip", frame_cnt, 1);
    check_val("locked_after_err", locked, 1);
    send_frame(4'b0000);
    after_edge;
    check_val("frame_cnt_2", frame_cnt, 2);

    // four bad frames in a row drop lock
    repeat (3) send_frame(4'b0100);
    after_edge;
    check_val("unlock_early", locked, 1);
    check_val("err_three_more", err_cnt, 4);
    send_frame(4'b0100);
    after_edge;
    check_val("unlock", locked, 0);
    check_val("unlock_valid", aligned_valid, 0);
    check_val("unlock_err", err_cnt, 5);
    check_val("unlock_frame", frame_cnt, 2);
    repeat (4) send_frame(4'b0000);
    after_edge;
    check_val("relock", locked, 1);
    check_val("relock_frame", frame_cnt, 2);

    // rx_ready drop for 3 cycles
    @(negedge aclk);
    rx_ready = 1'b0;
    rx_data  = pat[0];
    rx_is_k  = pk[0];
    after_edge;
    check_val("drop_locked_1", locked, 0);
    drive(pat[1], pk[1]);
    after_edge;
    check_val("drop_locked_2", locked, 0);
    check_val("drop_valid_2", aligned_valid, 0);
    check_val("drop_frame_hold", frame_cnt, 2);
    check_val("drop_err_hold", err_cnt, 5);
    drive(pat[2], pk[2]);
    @(negedge aclk);
    rx_ready = 1'b1;
    rx_data  = pat[3];
    rx_is_k  = pk[3];
    repeat (3) send_frame(4'b0000);
    after_edge;
    check_val("drop_relock_early", locked, 0);
    send_frame(4'b0000);
    after_edge;
    check_val("drop_relock", locked, 1);

    // asynchronous reset in the middle of a frame
    drive(pat[0], pk[0]);
    drive(pat[1], pk[1]);
    after_edge;
    #2;
    aresetn = 1'b0;
    #1;
    check_val("async_locked", locked, 0);
    check_val("async_lane", lane_swap, 0);
    check_val("async_valid", aligned_valid, 0);
    check_val("async_data", aligned_data, 0);
    check_val("async_is_k", aligned_is_k, 0);
    check_val("async_frame", frame_cnt, 0);
    check_val("async_err", err_cnt, 0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;

    // byte-shifted stream selects the shifted lane
    for (int s = 0; s < 20; s++) send_shift(s % 4);
    after_edge;
    check_val("lock_shift", locked, 1);
    check_val("lane_shift", lane_swap, 1);
    check_val("err_shift", err_cnt, 0);
    for (int s = 20; s < 24; s++) begin
      send_shift(s % 4);
      after_edge;
      check_val("shift_data", aligned_data, pat[(s - 1) % 4]);
      check_val("shift_is_k", aligned_is_k, pk[(s - 1) % 4]);
    end

    // comma visible in both lanes: direct lane wins
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    drive(16'hBC00, 2'b10);
    drive(pat[0], pk[0]);
    after_edge;
    check_val("both_hit_lane", lane_swap, 0);
    check_val("both_hit_unlocked", locked, 0);
    for (int s = 1; s < 16; s++) drive(pat[s % 4], pk[s % 4]);
    after_edge;
    check_val("both_hit_lock", locked, 1);

    // drive err_cnt to 15 without losing lock, then saturate
    repeat (3) send_frame(4'b1110);
    send_frame(4'b0000);
    repeat (2) send_frame(4'b1110);
    send_frame(4'b0000);
    after_edge;
    check_val("w4_err_15", w4_err_cnt, 4'hF);
    check_val("err_15", err_cnt, 15);
    check_val("frame_2_sat_phase", frame_cnt, 2);
    check_val("sat_locked", locked, 1);
    send_frame(4'b0100);
    after_edge;
    check_val("w4_err_sat", w4_err_cnt, 4'hF);
    check_val("err_16", err_cnt, 16);

    drive(pat[0], pk[0]);
    drive(pat[1], pk[1]);
    @(negedge aclk);
    cnt_clear = 1'b1;
    rx_data   = pat[2] ^ 16'h0001;
    rx_is_k   = pk[2];
    after_edge;
    check_val("w4_clear_wins", w4_err_cnt, 0);
    check_val("clear_wins", err_cnt, 0);
    check_val("clear_frame", frame_cnt, 0);
    @(negedge aclk);
    cnt_clear = 1'b0;
    rx_data   = pat[3];
    rx_is_k   = pk[3];
    after_edge;
    check_val("clear_locked", locked, 1);
    check_val("clear_err_hold", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
